fixed_to_float_pipe: RTL and testbench

Parametrised, fully pipelined converter from signed two's-complement fixed point to IEEE-754-style binary floating point. It replaces the hand-sequenced single-precision converter, which needed external enables, LOAD and mux selects. This block uses a valid/ready stream interface, accepts one operand per cycle, and rounds to nearest-even with status flags. It sits between the CORDIC fixed-point datapath output and the floating-point consumers.

---
 rtl/fixed_to_float_pipe.sv | 155 +++++++++++++++
 tb/tb_fixed_to_float_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float_pipe.sv
// rtl/fixed_to_float_pipe.sv - three-stage signed fixed-point to binary float converter
module fixed_to_float_pipe #(
    parameter int FXW  = 32,
    parameter int FRAC = 26,
    parameter int EW   = 8,
    parameter int MW   = 23
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [FXW-1:0]   FIXED,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [EW+MW:0]   FLOATOUT,
    output logic             ZERO,
    output logic             INEXACT,
    output logic             OVF,
    output logic             UNF
);

    localparam int PW = $clog2(FXW);
    // Normalised fraction below the leading one, padded so guard/sticky always exist
    localparam int XW = FXW + MW + 1;
    localparam logic signed [EW+1:0] EXP_OFF = (EW+2)'((2**(EW-1)) - 1 - FRAC);
    localparam logic signed [EW+1:0] EXP_MAX = (EW+2)'((2**EW) - 1);

    logic stall;
    assign stall    = OUT_VALID & ~OUT_READY;
    assign IN_READY = ~stall;

    // Stage 1 registers: sign and magnitude
    logic           s1_valid_q, s1_sign_q;
    logic [FXW-1:0] s1_mag_q, s1_mag_d;

    // Stage 2 registers: normalised magnitude with the leading one stripped
    logic           s2_valid_q, s2_sign_q, s2_zero_q, s2_zero_d;
    logic [PW-1:0]  s2_p_q, s2_p_d;
    logic [FXW-2:0] s2_norm_q, s2_norm_d;

    // Stage 3 registers drive the outputs directly
    logic           out_valid_q, zero_q, inexact_q, ovf_q, unf_q;
    logic           zero_d, inexact_d, ovf_d, unf_d;
    logic [EW+MW:0] float_q, float_d;

    // Two's-complement negate; the most negative input maps to 2^(FXW-1) unsigned
    assign s1_mag_d = FIXED[FXW-1] ? -FIXED : FIXED;

    // Stage 1 pipeline register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
        end else if (!stall) begin
            s1_valid_q <= IN_VALID;
            s1_sign_q  <= FIXED[FXW-1];
            s1_mag_q   <= s1_mag_d;
        end
    end

    // Leading-one priority encoder and normalising left shift
    logic [FXW-1:0] shifted;
    always_comb begin
        s2_p_d = '0;
        for (int i = 0; i < FXW; i++) begin
            if (s1_mag_q[i]) s2_p_d = PW'(i);
        end
        shifted   = s1_mag_q << (PW'(FXW-1) - s2_p_d);
        // The leading one reaches the top bit for every nonzero magnitude
        s2_zero_d = ~shifted[FXW-1];
        s2_norm_d = shifted[FXW-2:0];
    end

    // Stage 2 pipeline register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_p_q     <= '0;
            s2_norm_q  <= '0;
        end else if (!stall) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_zero_q  <= s2_zero_d;
            s2_p_q     <= s2_p_d;
            s2_norm_q  <= s2_norm_d;
        end
    end

    // Round to nearest even, exponent bias, saturation and flush
    logic [XW-1:0]          ext;
    logic [MW-1:0]          mant;
    logic [MW:0]            mant_sum;
    logic                   guard, sticky, round_inc;
    logic signed [EW+1:0]   exp_base, exp_rnd;
    always_comb begin
        ext       = {s2_norm_q, {(MW+2){1'b0}}};
        mant      = ext[XW-1 -: MW];
        guard     = ext[XW-1-MW];
        sticky    = |ext[XW-2-MW:0];
        round_inc = guard & (sticky | mant[0]);
        mant_sum  = {1'b0, mant} + {{MW{1'b0}}, round_inc};
        exp_base  = $signed({{(EW+2-PW){1'b0}}, s2_p_q}) + EXP_OFF;
        exp_rnd   = exp_base + $signed({{(EW+1){1'b0}}, mant_sum[MW]});

        float_d   = '0;
        zero_d    = 1'b0;
        inexact_d = 1'b0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        if (s2_zero_q) begin
            zero_d = 1'b1;
        end else begin
            inexact_d = guard | sticky;
            if (exp_rnd >= EXP_MAX) begin
                ovf_d   = 1'b1;
                float_d = {s2_sign_q, {EW{1'b1}}, {MW{1'b0}}};
            end else if (exp_rnd[EW+1] || (exp_rnd == '0)) begin
                unf_d   = 1'b1;
                float_d = {s2_sign_q, {(EW+MW){1'b0}}};
            end else begin
                float_d = {s2_sign_q, exp_rnd[EW-1:0], mant_sum[MW-1:0]};
            end
        end
    end

    // Stage 3 output register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_q <= 1'b0;
            float_q     <= '0;
            zero_q      <= 1'b0;
            inexact_q   <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= s2_valid_q;
            float_q     <= float_d;
            zero_q      <= zero_d;
            inexact_q   <= inexact_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign FLOATOUT  = float_q;
    assign ZERO      = zero_q;
    assign INEXACT   = inexact_q;
    assign OVF       = ovf_q;
    assign UNF       = unf_q;

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// tb/tb_fixed_to_float_pipe.sv - randomized scoreboard bench for fixed_to_float_pipe
module tb_fixed_to_float_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] fixed, floatout;
    logic        zero, inexact, ovf, unf;

    logic        va, vb, ra, rb, ova, ovb, sweep_rdy;
    logic [15:0] fx_a, fx_b;
    logic [7:0]  fa, fb;
    logic        za, ia, oa, ua, zb, ib, ob, ub;

    fixed_to_float_pipe #(.FXW(32), .FRAC(26), .EW(8), .MW(23)) u_dut (
        .CLK(clk), .RST(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready), .FIXED(fixed),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .FLOATOUT(floatout),
        .ZERO(zero), .INEXACT(inexact), .OVF(ovf), .UNF(unf));

    fixed_to_float_pipe #(.FXW(16), .FRAC(0), .EW(4), .MW(3)) u_sweep_a (
        .CLK(clk), .RST(rst_n), .IN_VALID(va), .IN_READY(ra), .FIXED(fx_a),
        .OUT_VALID(ova), .OUT_READY(sweep_rdy), .FLOATOUT(fa),
        .ZERO(za), .INEXACT(ia), .OVF(oa), .UNF(ua));

    fixed_to_float_pipe #(.FXW(16), .FRAC(15), .EW(4), .MW(3)) u_sweep_b (
        .CLK(clk), .RST(rst_n), .IN_VALID(vb), .IN_READY(rb), .FIXED(fx_b),
        .OUT_VALID(ovb), .OUT_READY(sweep_rdy), .FLOATOUT(fb),
        .ZERO(zb), .INEXACT(ib), .OVF(ob), .UNF(ub));

    typedef struct {
        longint fl;
        bit     z, ix, ov, un;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    bit          stalled_prev = 1'b0;
    logic [31:0] prev_fl;
    logic [3:0]  prev_flags;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Exact value arithmetic: find floor(log2), divide down, round half to even
    function automatic res_t model(input longint fx, input int fxw, input int frac,
                                   input int ew, input int mw);
        res_t   r;
        longint one, mag, q, rem, half;
        int     p, sh, e;
        bit     s;
        r   = '{default: 0};
        one = 1;
        s   = fx[fxw-1];
        mag = s ? (one << fxw) - fx : fx;
        if (mag == 0) begin
            r.z = 1'b1;
            return r;
        end
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        if (p > mw) begin
            sh   = p - mw;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = one << (sh - 1);
            r.ix = (rem != 0);
            if (rem > half || (rem == half && q[0])) q++;
        end else begin
            q = mag << (mw - p);
        end
        if (q == (one << (mw + 1))) begin
            q = q >> 1;
            p++;
        end
        e = p - frac + (1 << (ew - 1)) - 1;
        if (e >= (1 << ew) - 1) begin
            r.ov = 1'b1;
            r.fl = (longint'(s) << (ew + mw)) | (((one << ew) - 1) << mw);
        end else if (e <= 0) begin
            r.un = 1'b1;
            r.fl = longint'(s) << (ew + mw);
        end else begin
            r.fl = (longint'(s) << (ew + mw)) | (longint'(e) << mw) | (q - (one << mw));
        end
        return r;
    endfunction

    task automatic step(input bit iv, input logic [31:0] fx, input bit ordy);
        res_t r;
        @(negedge clk);
        in_valid  = iv;
        fixed     = fx;
        out_ready = ordy;
        #1;
        if (stalled_prev) begin
            check_eq("stall_hold_float", floatout, prev_fl);
            check_eq("stall_hold_flags", {zero, inexact, ovf, unf}, prev_flags);
        end
        if (out_valid && !ordy) check_eq("in_ready_stalled", in_ready, 0);
        else                    check_eq("in_ready_free", in_ready, 1);
        if (iv && in_ready) exp_q.push_back(model(longint'(fx), 32, 26, 8, 23));
        if (out_valid && ordy) begin
            check_eq("result_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check_eq("float", floatout, r.fl);
                check_eq("flags", {zero, inexact, ovf, unf}, {r.z, r.ix, r.ov, r.un});
            end
        end
        stalled_prev = out_valid && !ordy;
        prev_fl      = floatout;
        prev_flags   = {zero, inexact, ovf, unf};
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 32'h0, 1'b1);
        check_eq("drained", exp_q.size(), 0);
    endtask

    logic [31:0] dir_in  [7] = '{32'h04000000, 32'hFC000000, 32'h80000000, 32'h00000000,
                                 32'h7FFFFFFF, 32'h01000001, 32'h01000003};
    logic [31:0] dir_out [7] = '{32'h3F800000, 32'hBF800000, 32'hC2000000, 32'h00000000,
                                 32'h42000000, 32'h3E800000, 32'h3E800002};
    logic [3:0]  dir_flg [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000,
                                 4'b0100, 4'b0100, 4'b0100};

    initial begin
        longint ha[$], hb[$];
        longint a, b;
        res_t   r;
        logic [31:0] v;

        rst_n = 1'b0; in_valid = 1'b0; fixed = '0; out_ready = 1'b1;
        va = 1'b0; vb = 1'b0; fx_a = '0; fx_b = '0; sweep_rdy = 1'b1;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_float", floatout, 0);
        check_eq("rst_flags", {zero, inexact, ovf, unf}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed values with three-cycle latency
        for (int i = 0; i < 7; i++) begin
            step(1'b1, dir_in[i], 1'b1);
            step(1'b0, 32'h0, 1'b1);
            check_eq("lat_c1", out_valid, 0);
            step(1'b0, 32'h0, 1'b1);
            check_eq("lat_c2", out_valid, 0);
            step(1'b0, 32'h0, 1'b1);
            check_eq("lat_c3", out_valid, 1);
            check_eq("dir_float", floatout, dir_out[i]);
            check_eq("dir_flags", {zero, inexact, ovf, unf}, dir_flg[i]);
        end
        drain();

        // Eight back-to-back operands under random backpressure
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'($urandom_range(0, 1)));
        drain();

        // Long random run with mixed magnitudes
        for (int i = 0; i < 300; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1)) v = -v;
            step(1'($urandom_range(0, 3) != 0), v, 1'($urandom_range(0, 2) != 0));
        end
        drain();

        // Mid-stream reset while stalled with work in flight
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0);
        check_eq("pre_rst_valid", out_valid, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_float", floatout, 0);
        exp_q.delete();
        stalled_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h04000000, 1'b1);
        step(1'b1, 32'hFC000000, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("post_rst_first", floatout, 32'h3F800000);
        drain();

        // Narrow parameter sweeps with continuous streaming
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            va   = 1'b1;
            vb   = 1'b1;
            fx_a = (c == 0) ? 16'h7FFF : (c == 1) ? 16'h0001 : (c == 2) ? 16'h8000 : 16'($urandom);
            fx_b = (c == 0) ? 16'h0001 : (c == 1) ? 16'h0000 : 16'($urandom);
            #1;
            ha.push_back(longint'(fx_a));
            hb.push_back(longint'(fx_b));
            if (ha.size() == 4) begin
                a = ha.pop_front();
                b = hb.pop_front();
                r = model(a, 16, 0, 4, 3);
                check_eq("sweep_a_valid", ova, 1);
                check_eq("sweep_a_float", fa, r.fl);
                check_eq("sweep_a_flags", {za, ia, oa, ua}, {r.z, r.ix, r.ov, r.un});
                r = model(b, 16, 15, 4, 3);
                check_eq("sweep_b_valid", ovb, 1);
                check_eq("sweep_b_float", fb, r.fl);
                check_eq("sweep_b_flags", {zb, ib, ob, ub}, {r.z, r.ix, r.ov, r.un});
                if (c == 3) begin
                    check_eq("ovf_float", fa, 8'h78);
                    check_eq("ovf_flag", oa, 1);
                    check_eq("unf_float", fb, 8'h00);
                    check_eq("unf_flag", ub, 1);
                end
                if (c == 4) begin
                    check_eq("unit_float", fa, 8'h38);
                    check_eq("unit_flags", {za, ia, oa, ua}, 0);
                end
            end
        end
        va = 1'b0;
        vb = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
